// File: rtl/mem_8x8_c_pp.sv
`default_nettype none
// =============================================================================
// mem_8x8_c_pp : double-buffered 8x8 transpose buffer, row-major in / column-major out
// Revision     : 1.0
// =============================================================================
module mem_8x8_c_pp #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] O,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last
);

   localparam logic [5:0] LAST_IDX = 6'd63;

   // Both banks share one array; the top address bit selects the bank.
   logic [WIDTH-1:0] ram [128];

   logic [1:0]       full_q, full_d;
   logic             wr_bank_q, wr_bank_d;
   logic             rd_bank_q, rd_bank_d;
   logic [5:0]       k_q, k_d;
   logic [5:0]       m_q, m_d;
   logic [WIDTH-1:0] o_q, o_d;
   logic             out_valid_q, out_valid_d;
   logic             out_last_q, out_last_d;

   logic             wr_fire;
   logic             ld;
   logic [6:0]       wr_addr;
   logic [6:0]       rd_addr;
   logic [WIDTH-1:0] rd_word;

   assign in_ready  = !full_q[wr_bank_q];
   assign wr_fire   = in_valid && in_ready;
   assign ld        = full_q[rd_bank_q] && (!out_valid_q || out_ready);

   // Write address is k itself (row = k[5:3]); the read swaps the index halves.
   assign wr_addr   = {wr_bank_q, k_q};
   assign rd_addr   = {rd_bank_q, m_q[2:0], m_q[5:3]};
   assign rd_word   = ram[rd_addr];

   assign O         = o_q;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         ram[wr_addr] <= in;
      end
   end

   always_comb begin
      full_d      = full_q;
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      k_d         = k_q;
      m_d         = m_q;
      o_d         = o_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;

      if (wr_fire) begin
         k_d = k_q + 6'd1;
         if (k_q == LAST_IDX) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
         end
      end

      // The read bank is always the other bank when both sides finish together.
      if (ld) begin
         o_d         = rd_word;
         out_valid_d = 1'b1;
         out_last_d  = (m_q == LAST_IDX);
         m_d         = m_q + 6'd1;
         if (m_q == LAST_IDX) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
         end
      end else if (out_ready) begin
         out_valid_d = 1'b0;
         out_last_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         full_q      <= 2'b00;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         k_q         <= 6'd0;
         m_q         <= 6'd0;
         o_q         <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         full_q      <= full_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         k_q         <= k_d;
         m_q         <= m_d;
         o_q         <= o_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

endmodule
`default_nettype wire
